chunked_serial_adder: RTL and testbench

- Parametrised multi-cycle adder that computes WIDTH-bit a + b + ci, CHUNK bits per clock.
- Operands are captured on a start pulse. Sum and carry-out come back with a one-cycle done pulse.
- Intended as the area-reduced successor to the single-bit full adder. Used wherever wide additions can tolerate WIDTH/CHUNK cycles of latency.

---
 rtl/chunked_serial_adder.sv | 110 +++++++++++
 tb/tb_chunked_serial_adder.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/chunked_serial_adder.sv
// Multi-cycle WIDTH-bit adder, CHUNK bits per clock; done pulses with sum/cout.
// Define CHUNKED_ADDER_OVF_EN to add the signed overflow output ovf.
module chunked_serial_adder #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             ci,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
`ifdef CHUNKED_ADDER_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int IW = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

  typedef enum logic {
    IDLE,
    RUN
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] ra;
  logic [WIDTH-1:0] rb;
  logic [WIDTH-1:0] partial;
  logic [WIDTH-1:0] partial_n;
  logic             carry;
  logic [IW-1:0]    idx;

  logic [CHUNK-1:0] ca;
  logic [CHUNK-1:0] cb;
  logic [CHUNK-1:0] s;
  logic             c;
  logic             last;

  always_comb begin
    ca        = ra[idx*CHUNK +: CHUNK];
    cb        = rb[idx*CHUNK +: CHUNK];
    {c, s}    = {1'b0, ca} + {1'b0, cb}
              + {{CHUNK{1'b0}}, carry};
    partial_n = partial;
    partial_n[idx*CHUNK +: CHUNK] = s;
    last      = (idx == IW'(NCHUNK - 1));
  end

`ifdef CHUNKED_ADDER_OVF_EN
  // Carry into the MSB recovered from the MSB's own sum bit.
  logic msb_cin;
  assign msb_cin = ca[CHUNK-1] ^ cb[CHUNK-1] ^ s[CHUNK-1];
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
      sum     <= '0;
      cout    <= 1'b0;
      ra      <= '0;
      rb      <= '0;
      partial <= '0;
      carry   <= 1'b0;
      idx     <= '0;
`ifdef CHUNKED_ADDER_OVF_EN
      ovf     <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            ra      <= a;
            rb      <= b;
            carry   <= ci;
            partial <= '0;
            idx     <= '0;
            busy    <= 1'b1;
            state   <= RUN;
          end
        end
        RUN: begin
          partial <= partial_n;
          carry   <= c;
          idx     <= idx + 1'b1;
          if (last) begin
            sum   <= partial_n;
            cout  <= c;
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= IDLE;
`ifdef CHUNKED_ADDER_OVF_EN
            ovf   <= msb_cin ^ c;
`endif
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_chunked_serial_adder.sv
// Self-checking bench: directed cases plus random regression over five CHUNK
// sizes at WIDTH=16 and a degenerate WIDTH=CHUNK=8 instance.
module tb_chunked_serial_adder;

  logic        clk;
  logic        rst_n;
  logic [15:0] a16;
  logic [15:0] b16;
  logic        ci16;
  logic [4:0]  start_v;
  logic        busy_v [5];
  logic        done_v [5];
  logic [15:0] sum_v  [5];
  logic        cout_v [5];
`ifdef CHUNKED_ADDER_OVF_EN
  logic        ovf_v  [5];
  logic        ovf8;
`endif

  logic       start8;
  logic [7:0] a8;
  logic [7:0] b8;
  logic       ci8;
  logic       busy8;
  logic       done8;
  logic [7:0] sum8;
  logic       cout8;

  int checks = 0;
  int errors = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Instance g uses CHUNK = 2**g
  for (genvar g = 0; g < 5; g++) begin : g_dut
    chunked_serial_adder #(
      .WIDTH(16),
      .CHUNK(1 << g)
    ) u_dut (
      .clk  (clk),
      .rst_n(rst_n),
      .start(start_v[g]),
      .a    (a16),
      .b    (b16),
      .ci   (ci16),
      .busy (busy_v[g]),
      .done (done_v[g]),
      .sum  (sum_v[g]),
      .cout (cout_v[g])
`ifdef CHUNKED_ADDER_OVF_EN
      ,
      .ovf  (ovf_v[g])
`endif
    );
  end

  chunked_serial_adder #(
    .WIDTH(8),
    .CHUNK(8)
  ) u_dut8 (
    .clk  (clk),
    .rst_n(rst_n),
    .start(start8),
    .a    (a8),
    .b    (b8),
    .ci   (ci8),
    .busy (busy8),
    .done (done8),
    .sum  (sum8),
    .cout (cout8)
`ifdef CHUNKED_ADDER_OVF_EN
    ,
    .ovf  (ovf8)
`endif
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Issue one op on instance k and check latency, busy width and result.
  task automatic run_op(input int k,
                        input logic [15:0] av,
                        input logic [15:0] bv,
                        input logic civ,
                        input string tag);
    int          n;
    int          bc;
    int          lat;
    bit          seen;
    logic [16:0] exp;
    n    = 16 >> k;
    exp  = {1'b0, av} + {1'b0, bv} + {16'd0, civ};
    a16  = av;
    b16  = bv;
    ci16 = civ;
    start_v[k] = 1'b1;
    step();
    start_v[k] = 1'b0;
    a16  = ~av;
    b16  = ~bv;
    ci16 = ~civ;
    bc   = 0;
    lat  = 0;
    seen = 0;
    for (int c = 1; c <= 24 && !seen; c++) begin
      if (busy_v[k]) bc++;
      if (done_v[k]) begin
        seen = 1;
        lat  = c - 1;
      end else begin
        step();
      end
    end
    check({tag, "_seen"}, 32'(seen), 32'd1);
    if (seen) begin
      check({tag, "_lat"}, 32'(lat), 32'(n));
      check({tag, "_busy"}, 32'(bc), 32'(n));
      check({tag, "_res"}, 32'({cout_v[k], sum_v[k]}), 32'(exp));
      step();
      check({tag, "_pulse"}, 32'(done_v[k]), 32'd0);
    end
  endtask

  initial begin
    logic [15:0] ra;
    logic [15:0] rb;
    logic        rc;
    logic [16:0] exp;
    bit          seen;
    int          lat;
    int          k;

    rst_n   = 1'b0;
    start_v = '0;
    a16     = '0;
    b16     = '0;
    ci16    = 1'b0;
    start8  = 1'b0;
    a8      = '0;
    b8      = '0;
    ci8     = 1'b0;
    step();
    step();
    check("rst_busy", 32'(busy_v[2]), 32'd0);
    check("rst_done", 32'(done_v[2]), 32'd0);
    check("rst_sum", 32'(sum_v[2]), 32'd0);
    check("rst_cout", 32'(cout_v[2]), 32'd0);
    rst_n = 1'b1;
    step();

    run_op(2, 16'h1234, 16'h4321, 1'b0, "basic");
    check("basic_sum", 32'(sum_v[2]), 32'h5555);
    run_op(2, 16'hFFFF, 16'h0000, 1'b1, "ripple");
    check("ripple_sum", 32'(sum_v[2]), 32'h0000);
    check("ripple_cout", 32'(cout_v[2]), 32'd1);
`ifdef CHUNKED_ADDER_OVF_EN
    run_op(2, 16'h7FFF, 16'h0001, 1'b0, "ovf");
    check("ovf_sum", 32'(sum_v[2]), 32'h8000);
    check("ovf_flag", 32'(ovf_v[2]), 32'd1);
    run_op(2, 16'h8000, 16'h0001, 1'b0, "noovf");
    check("noovf_flag", 32'(ovf_v[2]), 32'd0);
`endif

    // start held high while busy: only the first operands matter
    a16  = 16'h0F0F;
    b16  = 16'h1111;
    ci16 = 1'b1;
    start_v[2] = 1'b1;
    step();
    seen = 0;
    for (int c = 1; c <= 12 && !seen; c++) begin
      if (done_v[2]) begin
        seen = 1;
      end else begin
        a16  = 16'($urandom);
        b16  = 16'($urandom);
        ci16 = 1'($urandom);
        step();
      end
    end
    check("hold_seen", 32'(seen), 32'd1);
    check("hold_res", 32'({cout_v[2], sum_v[2]}), 32'h0_2021);
    // start in the done cycle is accepted
    a16  = 16'hA000;
    b16  = 16'h7000;
    ci16 = 1'b0;
    step();
    start_v[2] = 1'b0;
    seen = 0;
    lat  = 0;
    for (int c = 1; c <= 12 && !seen; c++) begin
      if (done_v[2]) begin
        seen = 1;
        lat  = c - 1;
      end else begin
        step();
      end
    end
    check("b2b_seen", 32'(seen), 32'd1);
    check("b2b_lat", 32'(lat), 32'd4);
    check("b2b_res", 32'({cout_v[2], sum_v[2]}), 32'h1_1000);
    step();

    // reset in the second RUN cycle abandons the op
    run_op(2, 16'h2222, 16'h3333, 1'b0, "pre_rst");
    a16  = 16'h1111;
    b16  = 16'h1111;
    start_v[2] = 1'b1;
    step();
    start_v[2] = 1'b0;
    step();
    check("mid_busy_pre", 32'(busy_v[2]), 32'd1);
    rst_n = 1'b0;
    #1;
    check("mid_busy", 32'(busy_v[2]), 32'd0);
    check("mid_sum", 32'(sum_v[2]), 32'd0);
    check("mid_cout", 32'(cout_v[2]), 32'd0);
    step();
    rst_n = 1'b1;
    seen = 0;
    for (int c = 0; c < 8; c++) begin
      step();
      if (done_v[2] || busy_v[2]) seen = 1;
    end
    check("mid_nodone", 32'(seen), 32'd0);

    // CHUNK = WIDTH: done one cycle after start
    a8     = 8'hC8;
    b8     = 8'h64;
    ci8    = 1'b0;
    start8 = 1'b1;
    step();
    start8 = 1'b0;
    check("w8_busy", 32'(busy8), 32'd1);
    step();
    check("w8_done", 32'(done8), 32'd1);
    check("w8_sum", 32'(sum8), 32'h2C);
    check("w8_cout", 32'(cout8), 32'd1);
    step();
    check("w8_pulse", 32'(done8), 32'd0);

    // random regression across all chunk sizes
    for (int i = 0; i < 1000; i++) begin
      k  = int'($urandom_range(4, 0));
      ra = 16'($urandom);
      rb = 16'($urandom);
      rc = 1'($urandom);
      if (i % 10 == 0) rb = ~ra;
      run_op(k, ra, rb, rc, $sformatf("rnd%0d_c%0d", i, 1 << k));
    end
    exp = 17'd0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
